// File: rtl/spk_tone_if.sv
// Load/status bus between the AVR speaker register wrapper and spk_tone_gen.
// The wrapper is the master: it drives clock enable, unmute, load strobe and
// note parameters, and reads back per-channel busy/done status.
interface spk_tone_if #(
    parameter int PER_W = 16,
    parameter int DUR_W = 16
);
    logic             clken;
    logic             spk_on;
    logic             ld;
    logic             ld_ch;
    logic [PER_W-1:0] ld_per;
    logic [DUR_W-1:0] ld_dur;
    logic [2:0]       vol;
    logic [1:0]       busy;
    logic [1:0]       done;

    modport master (
        output clken, spk_on, ld, ld_ch, ld_per, ld_dur, vol,
        input  busy, done
    );

    modport slave (
        input  clken, spk_on, ld, ld_ch, ld_per, ld_dur, vol,
        output busy, done
    );
endinterface

// File: rtl/spk_tone_gen.sv
// Two-channel square-wave tone generator. Each channel plays one timed note
// (half-period in clken cycles, duration in PRESC_DIV-cycle ticks), returns
// to idle and pulses done. Optional feature macro: SPK_VOLUME_EN, which adds
// a 3-bit PWM volume gate per channel latched from vol on load.
module spk_tone_gen #(
    parameter int PRESC_DIV = 16000,
    parameter int PER_W     = 16,
    parameter int DUR_W     = 16
) (
    input  logic       clk,
    input  logic       rstn,
    spk_tone_if.slave  bus,
    output logic       spk1_pin,
    output logic       spk2_pin
);
    localparam int PSC_W = (PRESC_DIV > 2) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESC_DIV - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    logic phase_a [2];
    logic busy_a  [2];
    logic done_a  [2];
`ifdef SPK_VOLUME_EN
    logic [2:0] vol_a [2];
    logic [2:0] pwm_cnt;
`else
    logic unused_vol;
    assign unused_vol = ^bus.vol;
`endif

    for (genvar g = 0; g < 2; g++) begin : g_ch
        state_t           state;
        logic [PER_W-1:0] per_r;
        logic [PER_W-1:0] half_cnt;
        logic [DUR_W-1:0] dur_cnt;
        logic [PSC_W-1:0] presc_cnt;
        logic             phase;
        logic             done_r;
        logic             sel;
`ifdef SPK_VOLUME_EN
        logic [2:0]       vol_r;
        assign vol_a[g] = vol_r;
`endif

        assign sel = bus.ld && (bus.ld_ch == (g == 1));

        // Channel FSM: load/stop handling, prescaler, duration and half-period counters.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                state     <= IDLE;
                per_r     <= '0;
                dur_cnt   <= '0;
                presc_cnt <= '0;
                half_cnt  <= '0;
                phase     <= 1'b0;
                done_r    <= 1'b0;
`ifdef SPK_VOLUME_EN
                vol_r     <= '0;
`endif
            end else begin
                done_r <= 1'b0;
                if (bus.clken) begin
                    if (sel) begin
                        phase <= 1'b0;
                        if (bus.ld_dur != '0) begin
                            state     <= PLAY;
                            per_r     <= bus.ld_per;
                            dur_cnt   <= bus.ld_dur;
                            presc_cnt <= '0;
                            half_cnt  <= '0;
`ifdef SPK_VOLUME_EN
                            vol_r     <= bus.vol;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end else if (state == PLAY) begin
                        if (per_r != '0) begin
                            if (half_cnt == per_r - PER_W'(1)) begin
                                half_cnt <= '0;
                                phase    <= ~phase;
                            end else begin
                                half_cnt <= half_cnt + PER_W'(1);
                            end
                        end
                        // Final-tick assignments come last so they override the phase toggle.
                        if (presc_cnt == PSC_LAST) begin
                            presc_cnt <= '0;
                            if (dur_cnt == DUR_W'(1)) begin
                                state  <= IDLE;
                                phase  <= 1'b0;
                                done_r <= 1'b1;
                            end else begin
                                dur_cnt <= dur_cnt - DUR_W'(1);
                            end
                        end else begin
                            presc_cnt <= presc_cnt + PSC_W'(1);
                        end
                    end
                end
            end
        end

        assign phase_a[g] = phase;
        assign busy_a[g]  = (state == PLAY);
        assign done_a[g]  = done_r;
    end

    assign bus.busy = {busy_a[1], busy_a[0]};
    assign bus.done = {done_a[1], done_a[0]};

`ifdef SPK_VOLUME_EN
    // Free-running PWM counter for the volume gate.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pwm_cnt <= '0;
        end else if (bus.clken) begin
            pwm_cnt <= pwm_cnt + 3'd1;
        end
    end
`endif

    // Registered speaker pins: phase gated by global unmute (and volume PWM).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            spk1_pin <= 1'b0;
            spk2_pin <= 1'b0;
        end else begin
`ifdef SPK_VOLUME_EN
            spk1_pin <= phase_a[0] & bus.spk_on & (pwm_cnt < vol_a[0]);
            spk2_pin <= phase_a[1] & bus.spk_on & (pwm_cnt < vol_a[1]);
`else
            spk1_pin <= phase_a[0] & bus.spk_on;
            spk2_pin <= phase_a[1] & bus.spk_on;
`endif
        end
    end
endmodule

// File: tb/tb_spk_tone_gen.sv
// Self-checking bench for spk_tone_gen: directed scenarios plus random
// stimulus, all compared cycle by cycle against an elapsed-time note model.
module tb_spk_tone_gen;
    localparam int P = 4;

    logic clk = 1'b0;
    logic rstn;
    logic spk1_pin, spk2_pin;

    spk_tone_if #(.PER_W(16), .DUR_W(16)) bus ();

    spk_tone_gen #(.PRESC_DIV(P), .PER_W(16), .DUR_W(16)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .spk1_pin (spk1_pin),
        .spk2_pin (spk2_pin)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a note is described by its parameters and the clken cycles elapsed since load.
    bit m_act [2];
    int m_per [2];
    int m_dur [2];
    int m_k   [2];
    int m_vol [2];
    int m_pwm;
    bit e_pin [2];
    bit e_done[2];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_phase(input int ch);
        if (!m_act[ch] || m_per[ch] == 0) return 1'b0;
        return ((m_k[ch] / m_per[ch]) % 2) == 1;
    endfunction

    // One clock cycle: drive inputs, advance model at the edge, compare 1 ns later.
    task automatic cyc(input bit rst, input bit ce, input bit on, input bit l, input bit lch,
                       input int per, input int dur, input int vol);
        bit ph;
        rstn        = !rst;
        bus.clken   = ce;
        bus.spk_on  = on;
        bus.ld      = l;
        bus.ld_ch   = lch;
        bus.ld_per  = 16'(per);
        bus.ld_dur  = 16'(dur);
        bus.vol     = 3'(vol);
        @(posedge clk);
        for (int ch = 0; ch < 2; ch++) begin
            ph = m_phase(ch);
`ifdef SPK_VOLUME_EN
            e_pin[ch] = ph && on && (m_pwm < m_vol[ch]);
`else
            e_pin[ch] = ph && on;
`endif
            e_done[ch] = 1'b0;
        end
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                m_act[ch] = 1'b0;
                e_pin[ch] = 1'b0;
            end
            m_pwm = 0;
        end else if (ce) begin
            m_pwm = (m_pwm + 1) % 8;
            for (int ch = 0; ch < 2; ch++) begin
                if (l && int'(lch) == ch) begin
                    if (dur != 0) begin
                        m_act[ch] = 1'b1;
                        m_per[ch] = per;
                        m_dur[ch] = dur;
                        m_vol[ch] = vol;
                        m_k[ch]   = 0;
                    end else begin
                        m_act[ch] = 1'b0;
                    end
                end else if (m_act[ch]) begin
                    m_k[ch]++;
                    if (m_k[ch] == m_dur[ch] * P) begin
                        m_act[ch]  = 1'b0;
                        e_done[ch] = 1'b1;
                    end
                end
            end
        end
        #1;
        check("busy0", int'(bus.busy[0]), int'(m_act[0]));
        check("busy1", int'(bus.busy[1]), int'(m_act[1]));
        check("done0", int'(bus.done[0]), int'(e_done[0]));
        check("done1", int'(bus.done[1]), int'(e_done[1]));
        check("spk1",  int'(spk1_pin),    int'(e_pin[0]));
        check("spk2",  int'(spk2_pin),    int'(e_pin[1]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 1, 0, 0, 0, 0, 0);
    endtask

    // Idle cycles until done[ch] pulses; n = cycles after the load, or -1 if the bound expires.
    task automatic wait_done(input int ch, input int limit, input bit on, input bit gate, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            cyc(0, gate ? (i % 2 == 0) : 1'b1, on, 0, 0, 0, 0, 0);
            if (bus.done[ch]) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        m_pwm = 0;
        for (int ch = 0; ch < 2; ch++) begin
            m_act[ch] = 0; m_per[ch] = 0; m_dur[ch] = 0; m_k[ch] = 0; m_vol[ch] = 0;
        end

        // Reset held 3 cycles with a load pending.
        repeat (3) cyc(1, 1, 1, 1, 0, 3, 5, 7);
        idle(2);

        // Basic note.
        cyc(0, 1, 1, 1, 0, 3, 5, 7);
        wait_done(0, 40, 1, 0, n);
        check("basic_lat", n, 20);
        idle(3);

        // Rest note.
        cyc(0, 1, 1, 1, 0, 0, 2, 7);
        wait_done(0, 40, 1, 0, n);
        check("rest_lat", n, 8);

        // Stop mid-note.
        cyc(0, 1, 1, 1, 0, 3, 5, 7);
        idle(6);
        cyc(0, 1, 1, 1, 0, 3, 0, 7);
        idle(25);

        // Muted note still times out.
        cyc(0, 1, 0, 1, 0, 3, 5, 7);
        wait_done(0, 40, 0, 0, n);
        check("mute_lat", n, 20);

        // Retrigger and channel independence.
        cyc(0, 1, 1, 1, 0, 3, 5, 7);
        idle(9);
        cyc(0, 1, 1, 1, 1, 2, 1, 5);
        idle(1);
        cyc(0, 1, 1, 1, 0, 1, 1, 6);
        idle(12);

        // clken gating stretches timing 2x.
        cyc(0, 1, 1, 1, 0, 3, 5, 7);
        wait_done(0, 80, 1, 1, n);
        check("gated_lat", n, 40);

        // Load while clken=0 is ignored.
        cyc(0, 0, 1, 1, 1, 3, 2, 7);
        idle(12);

        // Load on the final-tick cycle wins; no done.
        cyc(0, 1, 1, 1, 0, 3, 1, 7);
        idle(3);
        cyc(0, 1, 1, 1, 0, 2, 1, 7);
        wait_done(0, 20, 1, 0, n);
        check("final_tick_lat", n, 4);

        // Reset mid-note gives no done.
        cyc(0, 1, 1, 1, 1, 2, 5, 7);
        idle(5);
        repeat (2) cyc(1, 1, 1, 0, 0, 0, 0, 0);
        idle(25);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 499) == 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 7) != 0,
                $urandom_range(0, 9) == 0,
                1'($urandom_range(0, 1)),
                int'($urandom_range(0, 6)),
                int'($urandom_range(0, 5)),
                int'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
